// File: rtl/reservation_station_if.sv
// Dispatch / CDB / issue bundle for one reservation station.
// The master side is the environment (dispatch, CDB, functional unit).
// The slave side is the station itself.
interface reservation_station_if #(
   parameter int WORD_W = 32,
   parameter int TAG_W  = 6,
   parameter int OP_W   = 4,
   parameter int DEPTH  = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              flush;
   logic              alloc_valid;
   logic              alloc_ready;
   logic [OP_W-1:0]   alloc_op;
   logic [TAG_W-1:0]  alloc_dest;
   logic              alloc_s1_rdy;
   logic              alloc_s2_rdy;
   logic [WORD_W-1:0] alloc_s1_val;
   logic [WORD_W-1:0] alloc_s2_val;
   logic [TAG_W-1:0]  alloc_s1_tag;
   logic [TAG_W-1:0]  alloc_s2_tag;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [WORD_W-1:0] cdb_val;
   logic              issue_valid;
   logic              issue_ready;
   logic [OP_W-1:0]   issue_op;
   logic [TAG_W-1:0]  issue_dest;
   logic [WORD_W-1:0] issue_a;
   logic [WORD_W-1:0] issue_b;
   logic [CNT_W-1:0]  count;

   modport master (
      output flush, alloc_valid, alloc_op, alloc_dest,
             alloc_s1_rdy, alloc_s2_rdy, alloc_s1_val, alloc_s2_val,
             alloc_s1_tag, alloc_s2_tag, cdb_valid, cdb_tag, cdb_val, issue_ready,
      input  alloc_ready, issue_valid, issue_op, issue_dest, issue_a, issue_b, count
   );

   modport slave (
      input  flush, alloc_valid, alloc_op, alloc_dest,
             alloc_s1_rdy, alloc_s2_rdy, alloc_s1_val, alloc_s2_val,
             alloc_s1_tag, alloc_s2_tag, cdb_valid, cdb_tag, cdb_val, issue_ready,
      output alloc_ready, issue_valid, issue_op, issue_dest, issue_a, issue_b, count
   );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: buffers DEPTH ops, captures operands from the CDB by tag,
// and issues the oldest ready entry to one functional unit over valid/ready.
// Age is tracked with an elder matrix; a presented-but-unaccepted entry is held
// so the payload stays stable until the unit takes it.
module reservation_station #(
   parameter int WORD_W = 32,
   parameter int TAG_W  = 6,
   parameter int OP_W   = 4,
   parameter int DEPTH  = 8
) (
   input logic clk,
   input logic rst,
   reservation_station_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   // entry storage
   logic [DEPTH-1:0]             busy, s1_rdy, s2_rdy;
   logic [DEPTH-1:0][OP_W-1:0]   op;
   logic [DEPTH-1:0][TAG_W-1:0]  dest, s1_tag, s2_tag;
   logic [DEPTH-1:0][WORD_W-1:0] s1_val, s2_val;
   // elder[i][j] = 1 when entry j was allocated before entry i
   logic [DEPTH-1:0][DEPTH-1:0]  elder;

   logic [CNT_W-1:0] cnt;
   logic             hold_valid;
   logic [IDX_W-1:0] hold_idx;

   logic [DEPTH-1:0] ready;
   logic [IDX_W-1:0] free_idx, oldest_idx, sel_idx;
   logic             any_ready, present, do_alloc, do_accept;
   logic             s1_hit, s2_hit;

   assign ready     = busy & s1_rdy & s2_rdy;
   assign any_ready = |ready;
   assign present   = hold_valid | any_ready;
   assign sel_idx   = hold_valid ? hold_idx : oldest_idx;

   assign bus.alloc_ready = (cnt < CNT_W'(DEPTH));
   assign bus.count       = cnt;
   assign bus.issue_valid = present;
   assign bus.issue_op    = present ? op[sel_idx]     : '0;
   assign bus.issue_dest  = present ? dest[sel_idx]   : '0;
   assign bus.issue_a     = present ? s1_val[sel_idx] : '0;
   assign bus.issue_b     = present ? s2_val[sel_idx] : '0;

   assign do_alloc  = bus.alloc_valid && bus.alloc_ready;
   assign do_accept = present && bus.issue_ready;

   // a source still pending at dispatch can be satisfied by this cycle's broadcast
   assign s1_hit = bus.cdb_valid && !bus.alloc_s1_rdy && (bus.alloc_s1_tag == bus.cdb_tag);
   assign s2_hit = bus.cdb_valid && !bus.alloc_s2_rdy && (bus.alloc_s2_tag == bus.cdb_tag);

   // lowest-index free slot (descending scan so the lowest index wins)
   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!busy[i]) free_idx = IDX_W'(i);
   end

   // oldest ready entry: ready with no ready entry older than it
   always_comb begin
      oldest_idx = '0;
      for (int i = 0; i < DEPTH; i++)
         if (ready[i] && ((elder[i] & ready) == '0)) oldest_idx = IDX_W'(i);
   end

   // entry state: wakeup, free on accept, write on allocate, age update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= '0;
         s1_rdy <= '0;
         s2_rdy <= '0;
         op     <= '0;
         dest   <= '0;
         s1_tag <= '0;
         s2_tag <= '0;
         s1_val <= '0;
         s2_val <= '0;
         elder  <= '0;
      end else if (bus.flush) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.cdb_valid && busy[i] && !s1_rdy[i] && (s1_tag[i] == bus.cdb_tag)) begin
               s1_rdy[i] <= 1'b1;
               s1_val[i] <= bus.cdb_val;
            end
            if (bus.cdb_valid && busy[i] && !s2_rdy[i] && (s2_tag[i] == bus.cdb_tag)) begin
               s2_rdy[i] <= 1'b1;
               s2_val[i] <= bus.cdb_val;
            end
         end
         if (do_accept) busy[sel_idx] <= 1'b0;
         if (do_alloc) begin
            busy[free_idx]   <= 1'b1;
            op[free_idx]     <= bus.alloc_op;
            dest[free_idx]   <= bus.alloc_dest;
            s1_rdy[free_idx] <= bus.alloc_s1_rdy | s1_hit;
            s2_rdy[free_idx] <= bus.alloc_s2_rdy | s2_hit;
            s1_tag[free_idx] <= bus.alloc_s1_tag;
            s2_tag[free_idx] <= bus.alloc_s2_tag;
            s1_val[free_idx] <= s1_hit ? bus.cdb_val : bus.alloc_s1_val;
            s2_val[free_idx] <= s2_hit ? bus.cdb_val : bus.alloc_s2_val;
            // new entry is youngest: nobody treats it as elder, it sees every busy entry as elder
            for (int j = 0; j < DEPTH; j++) elder[j][free_idx] <= 1'b0;
            elder[free_idx] <= busy;
         end
      end
   end

   // occupancy count and issue hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         hold_valid <= 1'b0;
         hold_idx   <= '0;
      end else if (bus.flush) begin
         cnt        <= '0;
         hold_valid <= 1'b0;
      end else begin
         cnt <= cnt + CNT_W'(do_alloc) - CNT_W'(do_accept);
         if (do_accept) begin
            hold_valid <= 1'b0;
         end else if (present) begin
            hold_valid <= 1'b1;
            hold_idx   <= sel_idx;
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_reservation_station;
   localparam int WORD_W = 32;
   localparam int TAG_W  = 6;
   localparam int OP_W   = 4;
   localparam int DEPTH  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reservation_station_if #(.WORD_W(WORD_W), .TAG_W(TAG_W), .OP_W(OP_W), .DEPTH(DEPTH)) bus();

   reservation_station #(.WORD_W(WORD_W), .TAG_W(TAG_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic av; logic [3:0] op; logic [5:0] dest;
      logic r1; logic [31:0] v1; logic [5:0] t1;
      logic r2; logic [31:0] v2; logic [5:0] t2;
      logic cv; logic [5:0] ct; logic [31:0] cval;
      logic ir; logic fl;
      logic e_iv; logic [3:0] e_op; logic [5:0] e_dest;
      logic [31:0] e_a; logic [31:0] e_b; logic [3:0] e_cnt; logic e_ar;
   } vec_t;

   typedef struct {
      int id; logic [3:0] op; logic [5:0] dest;
      logic r1; logic [31:0] v1; logic [5:0] t1;
      logic r2; logic [31:0] v2; logic [5:0] t2;
   } ent_t;

   vec_t vt[14];
   ent_t q[$];
   ent_t ne, tmp;
   int held_id, next_id, pres, size0;
   logic av, r1, r2, cv, ir, fl;
   logic [3:0] rop;
   logic [5:0] rdest, t1, t2, ct;
   logic [31:0] v1, v2, cval;
   logic [73:0] want_pl;

   function automatic vec_t mk(
      logic av_, logic [3:0] op_, logic [5:0] dest_,
      logic r1_, logic [31:0] v1_, logic [5:0] t1_,
      logic r2_, logic [31:0] v2_, logic [5:0] t2_,
      logic cv_, logic [5:0] ct_, logic [31:0] cval_, logic ir_, logic fl_,
      logic e_iv_, logic [3:0] e_op_, logic [5:0] e_dest_,
      logic [31:0] e_a_, logic [31:0] e_b_, logic [3:0] e_cnt_, logic e_ar_);
      vec_t v;
      v.av = av_; v.op = op_; v.dest = dest_;
      v.r1 = r1_; v.v1 = v1_; v.t1 = t1_;
      v.r2 = r2_; v.v2 = v2_; v.t2 = t2_;
      v.cv = cv_; v.ct = ct_; v.cval = cval_; v.ir = ir_; v.fl = fl_;
      v.e_iv = e_iv_; v.e_op = e_op_; v.e_dest = e_dest_;
      v.e_a = e_a_; v.e_b = e_b_; v.e_cnt = e_cnt_; v.e_ar = e_ar_;
      return v;
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic drive(input logic av_, input logic [3:0] op_, input logic [5:0] dest_,
                        input logic r1_, input logic [31:0] v1_, input logic [5:0] t1_,
                        input logic r2_, input logic [31:0] v2_, input logic [5:0] t2_,
                        input logic cv_, input logic [5:0] ct_, input logic [31:0] cval_,
                        input logic ir_, input logic fl_);
      bus.alloc_valid  = av_;  bus.alloc_op     = op_;  bus.alloc_dest   = dest_;
      bus.alloc_s1_rdy = r1_;  bus.alloc_s1_val = v1_;  bus.alloc_s1_tag = t1_;
      bus.alloc_s2_rdy = r2_;  bus.alloc_s2_val = v2_;  bus.alloc_s2_tag = t2_;
      bus.cdb_valid    = cv_;  bus.cdb_tag      = ct_;  bus.cdb_val      = cval_;
      bus.issue_ready  = ir_;  bus.flush        = fl_;
   endtask

   task automatic idle(input logic ir_);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir_, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input logic iv, input logic [3:0] op_,
                          input logic [5:0] dest_, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] cnt, input logic ar);
      chk({name, "_valid"}, 80'(bus.issue_valid), 80'(iv));
      chk({name, "_payload"}, 80'({bus.issue_op, bus.issue_dest, bus.issue_a, bus.issue_b}),
          80'({op_, dest_, a, b}));
      chk({name, "_count"}, 80'(bus.count), 80'(cnt));
      chk({name, "_alloc_ready"}, 80'(bus.alloc_ready), 80'(ar));
   endtask

   initial begin
      idle(0);
      // reset check, single ready op
      vt[0]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,  0,0,0,0,0,0,1);
      vt[1]  = mk(1,3,5, 1,10,0, 1,20,0, 0,0,0, 1,0,  0,0,0,0,0,0,1);
      vt[2]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,3,5,10,20,1,1);
      vt[3]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,  0,0,0,0,0,0,1);
      // A waits tag 7, B ready; B held while A wakes
      vt[4]  = mk(1,1,1, 0,0,7, 1,2,0, 0,0,0, 0,0,  0,0,0,0,0,0,1);
      vt[5]  = mk(1,2,2, 1,3,0, 1,4,0, 0,0,0, 0,0,  0,0,0,0,0,1,1);
      vt[6]  = mk(0,0,0, 0,0,0, 0,0,0, 1,7,99, 0,0, 1,2,2,3,4,2,1);
      vt[7]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,  1,2,2,3,4,2,1);
      vt[8]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,2,2,3,4,2,1);
      vt[9]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,1,1,99,2,1,1);
      vt[10] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,  0,0,0,0,0,0,1);
      // allocation-cycle bypass on s2
      vt[11] = mk(1,0,3, 1,5,0, 0,0,12, 1,12,32'hDEAD, 1,0, 0,0,0,0,0,0,1);
      vt[12] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,  1,0,3,5,32'hDEAD,1,1);
      vt[13] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,  0,0,0,0,0,0,1);

      #12 rst = 1'b0;
      step();

      for (int k = 0; k < 14; k++) begin
         drive(vt[k].av, vt[k].op, vt[k].dest, vt[k].r1, vt[k].v1, vt[k].t1,
               vt[k].r2, vt[k].v2, vt[k].t2, vt[k].cv, vt[k].ct, vt[k].cval, vt[k].ir, vt[k].fl);
         chk_out($sformatf("vec%0d", k), vt[k].e_iv, vt[k].e_op, vt[k].e_dest,
                 vt[k].e_a, vt[k].e_b, vt[k].e_cnt, vt[k].e_ar);
         step();
      end

      // fill with entries all waiting on tag 20
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 4'(i), 6'(10 + i), 0, 0, 20, 1, 32'(i), 0, 0, 0, 0, 0, 0);
         chk("fill_count", 80'(bus.count), 80'(i));
         step();
      end
      // ninth alloc while full is dropped; broadcast wakes everything
      drive(1, 4'hF, 6'd40, 1, 1, 0, 1, 1, 0, 1, 20, 32'h55, 0, 0);
      chk_out("full", 0, 0, 0, 0, 0, 8, 0);
      step();
      idle(1);
      for (int i = 0; i < DEPTH; i++) begin
         chk_out($sformatf("drain%0d", i), 1, 4'(i), 6'(10 + i), 32'h55, 32'(i),
                 4'(DEPTH - i), (i != 0));
         step();
      end
      chk_out("drained", 0, 0, 0, 0, 0, 0, 1);

      // same-cycle alloc and accept at count 4
      for (int i = 0; i < 4; i++) begin
         drive(1, 4'(i), 6'(30 + i), 1, 32'(i), 0, 1, 32'(i + 100), 0, 0, 0, 0, 0, 0);
         step();
      end
      drive(1, 4'd4, 6'd34, 1, 4, 0, 1, 104, 0, 0, 0, 0, 1, 0);
      chk_out("aa_before", 1, 0, 30, 0, 100, 4, 1);
      step();
      // flush overrides alloc and accept
      drive(1, 4'd5, 6'd35, 1, 5, 0, 1, 105, 0, 0, 0, 0, 1, 1);
      chk_out("aa_after", 1, 1, 31, 1, 101, 4, 1);
      step();
      idle(0);
      chk_out("flush", 0, 0, 0, 0, 0, 0, 1);
      step();
      chk_out("flush_idle", 0, 0, 0, 0, 0, 0, 1);

      // asynchronous reset between edges
      drive(1, 4'd7, 6'd50, 1, 50, 0, 1, 51, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 4'd8, 6'd51, 1, 52, 0, 1, 53, 0, 0, 0, 0, 0, 0);
      step();
      idle(0);
      chk_out("pre_rst", 1, 7, 50, 50, 51, 2, 1);
      #2 rst = 1'b1;
      #1;
      chk_out("async_rst", 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk_out("post_rst", 0, 0, 0, 0, 0, 0, 1);

      // randomized traffic against the reference queue
      q.delete();
      held_id = -1;
      next_id = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         av = ($urandom % 4) != 0;  rop = 4'($urandom);  rdest = 6'($urandom);
         r1 = $urandom % 2;  v1 = $urandom;  t1 = 6'($urandom % 8);
         r2 = $urandom % 2;  v2 = $urandom;  t2 = 6'($urandom % 8);
         cv = ($urandom % 3) == 0;  ct = 6'($urandom % 8);  cval = $urandom;
         ir = ($urandom % 3) != 0;  fl = ($urandom % 64) == 0;
         drive(av, rop, rdest, r1, v1, t1, r2, v2, t2, cv, ct, cval, ir, fl);

         pres = -1;
         if (held_id >= 0) begin
            foreach (q[k]) if (q[k].id == held_id) pres = k;
         end else begin
            foreach (q[k]) if (pres < 0 && q[k].r1 && q[k].r2) pres = k;
         end
         want_pl = (pres >= 0) ? {q[pres].op, q[pres].dest, q[pres].v1, q[pres].v2} : '0;
         chk("rnd_valid", 80'(bus.issue_valid), 80'(pres >= 0));
         chk("rnd_payload", 80'({bus.issue_op, bus.issue_dest, bus.issue_a, bus.issue_b}),
             80'(want_pl));
         chk("rnd_count", 80'(bus.count), 80'(q.size()));
         chk("rnd_alloc_ready", 80'(bus.alloc_ready), 80'(q.size() < DEPTH));

         size0 = q.size();
         if (fl) begin
            q.delete();
            held_id = -1;
         end else begin
            if (pres >= 0) begin
               if (ir) begin
                  q.delete(pres);
                  held_id = -1;
               end else begin
                  held_id = q[pres].id;
               end
            end
            foreach (q[k]) begin
               tmp = q[k];
               if (cv && !tmp.r1 && tmp.t1 == ct) begin tmp.r1 = 1; tmp.v1 = cval; end
               if (cv && !tmp.r2 && tmp.t2 == ct) begin tmp.r2 = 1; tmp.v2 = cval; end
               q[k] = tmp;
            end
            if (av && size0 < DEPTH) begin
               ne.id = next_id;  next_id++;
               ne.op = rop;  ne.dest = rdest;
               ne.r1 = r1;  ne.v1 = v1;  ne.t1 = t1;
               ne.r2 = r2;  ne.v2 = v2;  ne.t2 = t2;
               if (cv && !r1 && t1 == ct) begin ne.r1 = 1; ne.v1 = cval; end
               if (cv && !r2 && t2 == ct) begin ne.r2 = 1; ne.v2 = cval; end
               q.push_back(ne);
            end
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
